// File: rtl/wallace_mac_accumulator.sv
// ---------------------------------------------------------------------------
// wallace_mac_accumulator
//
// Purpose:
//   Sums BURST_LEN consecutive unsigned products from the 4x4 Wallace
//   multiplier into one ACC_W-bit result. The result is then held on a
//   valid/ready output port together with a sticky saturation flag. While a
//   result is held, no new products are accepted. The next burst starts on
//   the cycle after the result has been taken.
//
// Parameters:
//   PROD_W    - width of incoming product
//   ACC_W     - accumulator/result width (must be >= PROD_W+1)
//   BURST_LEN - products summed per result (1..255)
//
// Ports:
//   clk        - system clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset
//   ena        - input enable; when low, input acceptance is blocked only
//   clear      - synchronous abort of any partial or held result
//   in_valid   - in_product is valid this cycle
//   in_ready   - block accepts in_product this cycle
//   in_product - unsigned product from the multiplier
//   out_valid  - out_sum/out_ovf hold a completed result
//   out_ready  - consumer takes the result this cycle
//   out_sum    - saturated unsigned sum of BURST_LEN products
//   out_ovf    - sum saturated at least once during this burst
//   busy       - a partial or held result exists
// ---------------------------------------------------------------------------
module wallace_mac_accumulator #(
    parameter int PROD_W    = 8,
    parameter int ACC_W     = 16,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    // An 8-bit counter covers the full 1..255 burst range.
    localparam int              CNT_W    = 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [ACC_W:0]   sum_ext;
    logic             accept;
    logic             transfer;

    // Output-side handshake signals. in_ready is gated by rst_n so that it
    // reads low while reset is held, even though the reset state is ACCUM.
    // The result port shows zero whenever no result is held.
    always_comb begin
        in_ready  = rst_n & (state_q == ST_ACCUM) & ena;
        out_valid = (state_q == ST_DONE);
        out_sum   = out_valid ? acc_q : '0;
        out_ovf   = out_valid ? ovf_q : 1'b0;
        busy      = (count_q != '0) | out_valid;
        accept    = in_valid & in_ready;
        transfer  = out_valid & out_ready;
    end

    // Next-state logic. The sum is formed one bit wider than the accumulator,
    // and that extra bit is the carry that triggers saturation. clear wins
    // over both handshakes, so a product or result offered in the same cycle
    // is dropped.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        sum_ext = {1'b0, acc_q} + (ACC_W + 1)'(in_product);

        if (clear) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            count_d = '0;
        end else if (accept) begin
            if (sum_ext[ACC_W]) begin
                acc_d = ACC_MAX;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum_ext[ACC_W-1:0];
            end
            if (count_q == LAST_CNT) begin
                state_d = ST_DONE;
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (transfer) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_wallace_mac_accumulator.sv
// ---------------------------------------------------------------------------
// tb_wallace_mac_accumulator
//
// Purpose:
//   Self-checking bench for wallace_mac_accumulator. Two instances share the
//   same stimulus: one uses the default 16-bit accumulator and the other uses
//   a 9-bit accumulator. A cycle model predicts handshakes and pushes the
//   expected result of every completed burst into a scoreboard queue. The
//   queue is checked whenever a result is held, and an entry is popped when
//   the result transfers.
// ---------------------------------------------------------------------------
module tb_wallace_mac_accumulator;

    localparam int BL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        clear;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  in_product;

    logic        in_ready16, out_valid16, out_ovf16, busy16;
    logic [15:0] out_sum16;
    logic        in_ready9, out_valid9, out_ovf9, busy9;
    logic [8:0]  out_sum9;

    typedef struct {
        logic [15:0] sum16;
        logic        ovf16;
        logic [8:0]  sum9;
        logic        ovf9;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    bit m_done;
    int m_count;
    int m_acc16;
    int m_acc9;
    bit m_ovf16;
    bit m_ovf9;

    wallace_mac_accumulator #(.PROD_W(8), .ACC_W(16), .BURST_LEN(BL)) dut16 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready16), .in_product(in_product),
        .out_valid(out_valid16), .out_ready(out_ready), .out_sum(out_sum16),
        .out_ovf(out_ovf16), .busy(busy16)
    );

    wallace_mac_accumulator #(.PROD_W(8), .ACC_W(9), .BURST_LEN(BL)) dut9 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready9), .in_product(in_product),
        .out_valid(out_valid9), .out_ready(out_ready), .out_sum(out_sum9),
        .out_ovf(out_ovf9), .busy(busy9)
    );

    // Free-running clock; rising edges fall at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Cycle model and scoreboard. The model runs on the falling edge, where
    // inputs and DUT outputs are both stable. It first compares the DUT
    // against its current state, then advances to the state the DUT will
    // take on the next rising edge.
    always @(negedge clk) begin
        bit exp_ready;
        bit exp_busy;
        if (!rst_n) begin
            m_done  = 1'b0;
            m_count = 0;
            m_acc16 = 0;
            m_acc9  = 0;
            m_ovf16 = 1'b0;
            m_ovf9  = 1'b0;
            sb.delete();
        end else begin
            exp_ready = !m_done && ena;
            exp_busy  = (m_count != 0) || m_done;
            checks++;
            if (in_ready16 !== exp_ready || in_ready9 !== exp_ready) begin
                errors++;
                $display("[TB] FAIL sb_in_ready: got %b/%b expected %b", in_ready16, in_ready9, exp_ready);
            end
            checks++;
            if (out_valid16 !== m_done || out_valid9 !== m_done) begin
                errors++;
                $display("[TB] FAIL sb_out_valid: got %b/%b expected %b", out_valid16, out_valid9, m_done);
            end
            checks++;
            if (busy16 !== exp_busy || busy9 !== exp_busy) begin
                errors++;
                $display("[TB] FAIL sb_busy: got %b/%b expected %b", busy16, busy9, exp_busy);
            end
            if (m_done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sb_empty: result held with no expected entry");
                end else if (out_sum16 !== sb[0].sum16 || out_ovf16 !== sb[0].ovf16 ||
                             out_sum9 !== sb[0].sum9 || out_ovf9 !== sb[0].ovf9) begin
                    errors++;
                    $display("[TB] FAIL sb_result: got sum16=%0d ovf16=%b sum9=%0d ovf9=%b expected sum16=%0d ovf16=%b sum9=%0d ovf9=%b",
                             out_sum16, out_ovf16, out_sum9, out_ovf9,
                             sb[0].sum16, sb[0].ovf16, sb[0].sum9, sb[0].ovf9);
                end
            end

            if (clear) begin
                m_done  = 1'b0;
                m_count = 0;
                m_acc16 = 0;
                m_acc9  = 0;
                m_ovf16 = 1'b0;
                m_ovf9  = 1'b0;
                sb.delete();
            end else if (!m_done && ena && in_valid) begin
                m_acc16 += int'(in_product);
                if (m_acc16 > 65535) begin
                    m_acc16 = 65535;
                    m_ovf16 = 1'b1;
                end
                m_acc9 += int'(in_product);
                if (m_acc9 > 511) begin
                    m_acc9 = 511;
                    m_ovf9 = 1'b1;
                end
                m_count++;
                if (m_count == BL) begin
                    sb.push_back('{16'(m_acc16), m_ovf16, 9'(m_acc9), m_ovf9});
                    m_done  = 1'b1;
                    m_count = 0;
                end
            end else if (m_done && out_ready) begin
                void'(sb.pop_front());
                m_done  = 1'b0;
                m_acc16 = 0;
                m_acc9  = 0;
                m_ovf16 = 1'b0;
                m_ovf9  = 1'b0;
            end
        end
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one product for a single cycle.
    task automatic push_product(input logic [7:0] p);
        in_valid   = 1'b1;
        in_product = p;
        tick();
    endtask

    // Outputs must be low while reset is held, even with ena high.
    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; clear = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; in_product = '0;
        #3;
        checks++;
        if (in_ready16 !== 1'b0 || out_valid16 !== 1'b0 || out_sum16 !== 16'd0 ||
            out_ovf16 !== 1'b0 || busy16 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b sum=%0d ovf=%b busy=%b expected all 0",
                     in_ready16, out_valid16, out_sum16, out_ovf16, busy16);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready16 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready: got %b expected 1", in_ready16);
        end
    endtask

    // T1: back-to-back burst, result one cycle after the final accept.
    task automatic test_basic_burst();
        push_product(8'd3); push_product(8'd5); push_product(8'd7); push_product(8'd9);
        in_valid = 1'b0;
        checks++;
        if (out_valid16 !== 1'b1 || out_sum16 !== 16'd24 || out_ovf16 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_result: got vld=%b sum=%0d ovf=%b expected vld=1 sum=24 ovf=0",
                     out_valid16, out_sum16, out_ovf16);
        end
        checks++;
        if (in_ready16 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_done_ready: got %b expected 0", in_ready16);
        end
        tick();
        checks++;
        if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_after_transfer: got vld=%b rdy=%b expected vld=0 rdy=1",
                     out_valid16, in_ready16);
        end
    endtask

    // T2: a result is held under backpressure and extra input is ignored.
    task automatic test_backpressure();
        out_ready = 1'b0;
        push_product(8'd3); push_product(8'd5); push_product(8'd7); push_product(8'd9);
        in_valid = 1'b1; in_product = 8'd99;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid16 !== 1'b1 || out_sum16 !== 16'd24 || in_ready16 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d: got vld=%b sum=%0d rdy=%b expected vld=1 sum=24 rdy=0",
                         i, out_valid16, out_sum16, in_ready16);
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid16 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_release: got vld=%b expected 0", out_valid16);
        end
        push_product(8'd1); push_product(8'd2); push_product(8'd3); push_product(8'd4);
        in_valid = 1'b0;
        checks++;
        if (out_sum16 !== 16'd10) begin
            errors++;
            $display("[TB] FAIL hold_next_burst: got %0d expected 10", out_sum16);
        end
        tick();
    endtask

    // T3: saturation in the 9-bit instance, then recovery on the next burst.
    task automatic test_saturation();
        for (int i = 0; i < 4; i++) push_product(8'd225);
        in_valid = 1'b0;
        checks++;
        if (out_sum9 !== 9'd511 || out_ovf9 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat9: got sum=%0d ovf=%b expected sum=511 ovf=1", out_sum9, out_ovf9);
        end
        checks++;
        if (out_sum16 !== 16'd900 || out_ovf16 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nosat16: got sum=%0d ovf=%b expected sum=900 ovf=0", out_sum16, out_ovf16);
        end
        tick();
        for (int i = 0; i < 4; i++) push_product(8'd1);
        in_valid = 1'b0;
        checks++;
        if (out_sum9 !== 9'd4 || out_ovf9 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sat9_recover: got sum=%0d ovf=%b expected sum=4 ovf=0", out_sum9, out_ovf9);
        end
        tick();
    endtask

    // T4: clear drops the partial sum and the product offered with it.
    task automatic test_clear();
        push_product(8'd10); push_product(8'd20);
        clear = 1'b1; in_valid = 1'b1; in_product = 8'd30;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        checks++;
        if (busy16 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_busy: got %b expected 0", busy16);
        end
        push_product(8'd1); push_product(8'd2); push_product(8'd3); push_product(8'd4);
        in_valid = 1'b0;
        checks++;
        if (out_sum16 !== 16'd10) begin
            errors++;
            $display("[TB] FAIL clear_sum: got %0d expected 10", out_sum16);
        end
        tick();
    endtask

    // T5: asynchronous reset in mid-cycle during a burst.
    task automatic test_reset_mid_burst();
        push_product(8'd10); push_product(8'd20);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready16 !== 1'b0 || out_valid16 !== 1'b0 || out_sum16 !== 16'd0 ||
            out_ovf16 !== 1'b0 || busy16 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got rdy=%b vld=%b sum=%0d ovf=%b busy=%b expected all 0",
                     in_ready16, out_valid16, out_sum16, out_ovf16, busy16);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) push_product(8'd1);
        in_valid = 1'b0;
        checks++;
        if (out_sum16 !== 16'd4) begin
            errors++;
            $display("[TB] FAIL midreset_sum: got %0d expected 4", out_sum16);
        end
        tick();
    endtask

    // T6: ena toggled between products with in_valid held high.
    task automatic test_ena_gating();
        logic [7:0] vals [4];
        vals[0] = 8'd2; vals[1] = 8'd4; vals[2] = 8'd6; vals[3] = 8'd8;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ena = 1'b1; in_product = vals[i];
            #1;
            checks++;
            if (in_ready16 !== 1'b1) begin
                errors++;
                $display("[TB] FAIL ena_high_ready%0d: got %b expected 1", i, in_ready16);
            end
            tick();
            if (i == 3) begin
                checks++;
                if (out_valid16 !== 1'b1 || out_sum16 !== 16'd20) begin
                    errors++;
                    $display("[TB] FAIL ena_sum: got vld=%b sum=%0d expected vld=1 sum=20", out_valid16, out_sum16);
                end
            end
            ena = 1'b0;
            #1;
            checks++;
            if (in_ready16 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL ena_low_ready%0d: got %b expected 0", i, in_ready16);
            end
            tick();
        end
        checks++;
        if (out_valid16 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ena_done_transfer: got vld=%b expected 0", out_valid16);
        end
        in_valid = 1'b0; ena = 1'b1;
        tick();
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_burst();
        test_backpressure();
        test_saturation();
        test_clear();
        test_reset_mid_burst();
        test_ena_gating();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
